// File: rtl/fog_demod_pkg.sv
// Shared constants and state encoding for the square-wave error demodulator.
package fog_demod_pkg;

  localparam int unsigned ADC_BIT_DEF = 16;
  localparam int unsigned ERR_BIT_DEF = 32;
  localparam int unsigned WAIT_BIT    = 32;
  localparam int unsigned AVG_BIT     = 4;
  localparam int unsigned STATE_BIT   = 3;

  typedef enum logic [STATE_BIT-1:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_H = 3'd1,
    ST_ACC_H  = 3'd2,
    ST_WAIT_L = 3'd3,
    ST_ACC_L  = 3'd4
  } demod_state_e;

endpackage

// File: rtl/demod_half_acc.sv
// Saturating signed accumulator for one modulation half, with clear,
// enable and a flag recording that at least one sample was taken.
module demod_half_acc
  import fog_demod_pkg::*;
#(
  parameter int unsigned ADC_BIT = ADC_BIT_DEF,
  parameter int unsigned ERR_BIT = ERR_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [ADC_BIT-1:0] din,
  output logic signed [ERR_BIT-1:0] sum,
  output logic                      has_sample
);

  localparam logic signed [ERR_BIT-1:0] SUM_MAX = {1'b0, {(ERR_BIT-1){1'b1}}};
  localparam logic signed [ERR_BIT-1:0] SUM_MIN = {1'b1, {(ERR_BIT-1){1'b0}}};

  logic        [ERR_BIT:0]   sum_wide;
  logic signed [ERR_BIT-1:0] sum_sat;

  // One guard bit: overflow when the two top bits disagree.
  always_comb begin
    sum_wide = {sum[ERR_BIT-1], sum}
             + {{(ERR_BIT+1-ADC_BIT){din[ADC_BIT-1]}}, din};
    if (sum_wide[ERR_BIT] != sum_wide[ERR_BIT-1])
      sum_sat = sum_wide[ERR_BIT] ? SUM_MIN : SUM_MAX;
    else
      sum_sat = sum_wide[ERR_BIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      has_sample <= 1'b0;
    end else if (clr) begin
      sum        <= '0;
      has_sample <= 1'b0;
    end else if (en) begin
      sum        <= sum_sat;
      has_sample <= 1'b1;
    end
  end

endmodule

// File: rtl/err_demod_gen.sv
// Demodulates the photodetector signal: blanks the start of each modulation
// half, accumulates both halves and emits the scaled difference per period.
module err_demod_gen
  import fog_demod_pkg::*;
#(
  parameter int unsigned ADC_BIT = ADC_BIT_DEF,
  parameter int unsigned ERR_BIT = ERR_BIT_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_status,
  input  logic                      i_stepTrig,
  input  logic signed [ADC_BIT-1:0] i_adc,
  input  logic [WAIT_BIT-1:0]       i_wait_cnt,
  input  logic [AVG_BIT-1:0]        i_avg_sel,
  output logic signed [ERR_BIT-1:0] o_err,
  output logic                      o_err_valid,
  output logic [STATE_BIT-1:0]      o_state
);

  localparam logic signed [ERR_BIT-1:0] ERR_MAX = {1'b0, {(ERR_BIT-1){1'b1}}};
  localparam logic signed [ERR_BIT-1:0] ERR_MIN = {1'b1, {(ERR_BIT-1){1'b0}}};

  demod_state_e              state_q, state_cur, state_d;
  logic                      status_q, rise, fall;
  logic [WAIT_BIT-1:0]       blank_cnt_q, blank_cnt_d, idx_cur, idx_next;
  logic [WAIT_BIT-1:0]       wait_q, wait_cur;
  logic                      trig_act, acc_h, acc_l, has_h, has_l, err_load;
  logic signed [ERR_BIT-1:0] sum_h, sum_l, err_sat, err_shift;
  logic        [ERR_BIT:0]   diff_wide;

  // Not reset: it keeps tracking i_status while in reset, so a release in the
  // middle of a half is not mistaken for an edge.
  always_ff @(posedge i_clk) status_q <= i_status;

  assign rise     = i_status & ~status_q;
  assign fall     = ~i_status & status_q;
  assign trig_act = i_stepTrig && (state_q != ST_IDLE);
  assign err_load = trig_act && has_h && has_l;

  // The edge cycle is cycle 0 of the new half, so it is resolved
  // combinationally; state_q holds the state of every non-edge cycle.
  always_comb begin
    state_cur = state_q;
    wait_cur  = wait_q;
    idx_cur   = blank_cnt_q;
    if (rise) begin
      state_cur = (i_wait_cnt == '0) ? ST_ACC_H : ST_WAIT_H;
      wait_cur  = i_wait_cnt;
      idx_cur   = '0;
    end else if (fall && (state_q != ST_IDLE)) begin
      state_cur = (i_wait_cnt == '0) ? ST_ACC_L : ST_WAIT_L;
      wait_cur  = i_wait_cnt;
      idx_cur   = '0;
    end
  end

  always_comb begin
    state_d     = state_cur;
    blank_cnt_d = idx_cur;
    idx_next    = idx_cur + 1'b1;
    case (state_cur)
      ST_WAIT_H: begin
        blank_cnt_d = idx_next;
        if (idx_next >= wait_cur) state_d = ST_ACC_H;
      end
      ST_WAIT_L: begin
        blank_cnt_d = idx_next;
        if (idx_next >= wait_cur) state_d = ST_ACC_L;
      end
      default: ;
    endcase
  end

  assign acc_h = (state_cur == ST_ACC_H) && !i_stepTrig;
  assign acc_l = (state_cur == ST_ACC_L) && !i_stepTrig;

  demod_half_acc #(.ADC_BIT(ADC_BIT), .ERR_BIT(ERR_BIT)) u_acc_h (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clr        (i_stepTrig),
    .en         (acc_h),
    .din        (i_adc),
    .sum        (sum_h),
    .has_sample (has_h)
  );

  demod_half_acc #(.ADC_BIT(ADC_BIT), .ERR_BIT(ERR_BIT)) u_acc_l (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clr        (i_stepTrig),
    .en         (acc_l),
    .din        (i_adc),
    .sum        (sum_l),
    .has_sample (has_l)
  );

  always_comb begin
    diff_wide = {sum_h[ERR_BIT-1], sum_h} - {sum_l[ERR_BIT-1], sum_l};
    if (diff_wide[ERR_BIT] != diff_wide[ERR_BIT-1])
      err_sat = diff_wide[ERR_BIT] ? ERR_MIN : ERR_MAX;
    else
      err_sat = diff_wide[ERR_BIT-1:0];
    err_shift = err_sat >>> i_avg_sel;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      blank_cnt_q <= '0;
      wait_q      <= '0;
      o_err       <= '0;
      o_err_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      wait_q      <= wait_cur;
      o_err_valid <= err_load;
      if (err_load) o_err <= err_shift;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_err_demod_gen.sv
// Bench for err_demod_gen: 32-bit and 20-bit instances on shared stimulus,
// checked every cycle against a sample-counting model plus literal values.
module tb_err_demod_gen;
  import fog_demod_pkg::*;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               status   = 1'b0;
  logic               trig     = 1'b0;
  logic signed [15:0] adc      = '0;
  logic [31:0]        wait_cnt = 32'd20;
  logic [3:0]         avg_sel  = '0;

  logic signed [31:0] err32;
  logic               v32;
  logic [2:0]         st32;
  logic signed [19:0] err20;
  logic               v20;
  logic [2:0]         st20;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  always #5 clk = ~clk;

  err_demod_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_stepTrig(trig),
    .i_adc(adc), .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel),
    .o_err(err32), .o_err_valid(v32), .o_state(st32)
  );

  err_demod_gen #(.ADC_BIT(16), .ERR_BIT(20)) dut20 (
    .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_stepTrig(trig),
    .i_adc(adc), .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel),
    .o_err(err20), .o_err_valid(v20), .o_state(st20)
  );

  // Model: half = 0 none, 1 high, 2 low; idx = cycles since the half began.
  // Index 0 of the per-width arrays models ERR_BIT 32, index 1 ERR_BIT 20.
  logic       m_prev = 1'b0;
  int         m_half = 0;
  longint     m_idx = 0, m_wait = 0;
  longint     sum_h[2] = '{0, 0};
  longint     sum_l[2] = '{0, 0};
  bit         has_h = 0, has_l = 0;
  longint     exp_err[2] = '{0, 0};
  bit         exp_valid = 0;
  logic [2:0] exp_state = 3'd0;
  int         width[2] = '{32, 20};

  function automatic longint sat(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_half = 0; m_idx = 0; m_wait = 0;
    has_h = 0; has_l = 0; exp_valid = 0; exp_state = ST_IDLE;
    for (int k = 0; k < 2; k++) begin
      sum_h[k] = 0; sum_l[k] = 0; exp_err[k] = 0;
    end
  endtask

  task automatic model_step();
    bit r, f, fired, acc;
    r = status && !m_prev;
    f = !status && m_prev;
    fired = trig && (m_half != 0);
    exp_valid = fired && has_h && has_l;
    if (exp_valid)
      for (int k = 0; k < 2; k++)
        exp_err[k] = sat(sum_h[k] - sum_l[k], width[k]) >>> avg_sel;
    if (r) begin
      m_half = 1; m_idx = 0; m_wait = longint'(wait_cnt);
    end else if (f && m_half != 0) begin
      m_half = 2; m_idx = 0; m_wait = longint'(wait_cnt);
    end else begin
      m_idx++;
    end
    acc = (m_half != 0) && (m_idx >= m_wait) && !trig;
    if (trig) begin
      has_h = 0; has_l = 0;
      for (int k = 0; k < 2; k++) begin sum_h[k] = 0; sum_l[k] = 0; end
    end
    if (acc) begin
      for (int k = 0; k < 2; k++)
        if (m_half == 1) sum_h[k] = sat(sum_h[k] + longint'(adc), width[k]);
        else             sum_l[k] = sat(sum_l[k] + longint'(adc), width[k]);
      if (m_half == 1) has_h = 1; else has_l = 1;
    end
    if (m_half == 0)              exp_state = ST_IDLE;
    else if (m_idx + 1 >= m_wait) exp_state = (m_half == 1) ? ST_ACC_H : ST_ACC_L;
    else                          exp_state = (m_half == 1) ? ST_WAIT_H : ST_WAIT_L;
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    m_prev = status;
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("err32",   longint'(err32), exp_err[0]);
    check("err20",   longint'(err20), exp_err[1]);
    check("valid32", longint'(v32),   longint'(exp_valid));
    check("valid20", longint'(v20),   longint'(exp_valid));
    check("state32", longint'(st32),  longint'(exp_state));
    check("state20", longint'(st20),  longint'(exp_state));
    if (v32) vcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 200-cycle modulation period, trigger on the rising edge; rst_at >= 0
  // holds reset low for 3 cycles starting at that cycle.
  task automatic run_period(input logic signed [15:0] adc_h,
                            input logic signed [15:0] adc_l,
                            input int rst_at);
    for (int c = 0; c < 200; c++) begin
      status = (c < 100);
      trig   = (c == 0);
      adc    = (c < 100) ? adc_h : adc_l;
      if (rst_at >= 0 && c == rst_at)     rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 3) rst_n = 1'b1;
      tick();
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_err",   longint'(err32), 0);
        check("rst_valid", longint'(v32),   0);
        check("rst_state", longint'(st32),  longint'(ST_IDLE));
      end
    end
  endtask

  initial begin
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    check("reset_err",   longint'(err32), 0);
    check("reset_valid", longint'(v32),   0);
    check("reset_state", longint'(st32),  longint'(ST_IDLE));

    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      trig = 1'b1; tick();
      trig = 1'b0; tick(); tick();
    end
    check("idle_trig_state", longint'(st32), longint'(ST_IDLE));
    check("idle_trig_valid", vcount, 0);

    wait_cnt = 32'd20; avg_sel = 4'd0; vcount = 0;
    repeat (3) run_period(16'sd1000, -16'sd1000, -1);
    check("basic_err",    longint'(err32), 160000);
    check("basic_err20",  longint'(err20), 160000);
    check("basic_vcount", vcount, 2);

    avg_sel = 4'd4;
    run_period(16'sd1000, -16'sd1000, -1);
    check("avg4_err", longint'(err32), 10000);

    avg_sel = 4'd0;
    run_period(16'sd1000, 16'sd1000, -1);
    run_period(16'sd1000, 16'sd1000, -1);
    check("const_err", longint'(err32), 0);

    run_period(16'sd1000, -16'sd1000, -1);
    wait_cnt = 32'd150;
    run_period(16'sd1000, -16'sd1000, -1);
    vcount = 0;
    run_period(16'sd1000, -16'sd1000, -1);
    run_period(16'sd1000, -16'sd1000, -1);
    check("longwait_vcount", vcount, 0);
    check("longwait_hold",   longint'(err32), 160000);

    wait_cnt = 32'd20;
    run_period(16'sd1000, -16'sd1000, -1);
    run_period(16'sd1000, -16'sd1000, 50);
    check("post_rst_state", longint'(st32), longint'(ST_IDLE));
    vcount = 0;
    run_period(16'sd1000, -16'sd1000, -1);
    run_period(16'sd1000, -16'sd1000, -1);
    check("resync_vcount", vcount, 1);
    check("resync_err",    longint'(err32), 160000);

    wait_cnt = 32'd0;
    run_period(16'sd32767, 16'sd0, -1);
    run_period(16'sd32767, -16'sd32768, -1);
    check("sat_h_err20", longint'(err20), 524287);
    check("sat_h_err32", longint'(err32), 3243933);
    run_period(16'sd32767, -16'sd32768, -1);
    check("sat_diff_err20", longint'(err20), 524287);
    check("sat_diff_err32", longint'(err32), 6520733);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
